// File: rtl/bdd_result_collector.sv
// Collects decision-tree leaf results and emits the majority class per sample.
// Latency: last pop of a sample -> out_valid after NCLASS cycles of counter scan.
// Backpressure: in_ready = FIFO not full; the winner is held in EMIT until out_ready.
module bdd_result_collector #(
  parameter int DEPTH  = 8,
  parameter int NCLASS = 16,
  parameter int TREES  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8:0]               in_class,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_class,
  output logic [7:0]               out_votes,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NCLASS > 1) ? $clog2(NCLASS) : 1;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [8:0]    NCLASS_W = 9'(NCLASS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NCLASS - 1);
  localparam logic [7:0]    LAST_RCV = 8'(TREES - 1);

  typedef enum logic [1:0] {ACCUM, SCAN, EMIT, CLEAR} state_t;

  // FIFO storage and pointers (one extra pointer bit distinguishes full from empty)
  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push, pop;

  // Vote tally and scan state
  state_t        state_q;
  logic [7:0]    cnt_q [NCLASS];
  logic [7:0]    rcv_q;
  logic [CW-1:0] idx_q;
  logic [7:0]    best_cnt_q;
  logic [7:0]    best_id_q;
  logic          out_valid_q;
  logic [7:0]    out_class_q;
  logic [7:0]    out_votes_q;
  logic          err_q;

  // Popped entry decode and scan comparison
  logic [8:0] pop_dat;
  logic [7:0] pop_id;
  logic       pop_vote;
  logic       scan_hit;
  logic [7:0] scan_cnt_d;
  logic [7:0] scan_id_d;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign in_ready = (level != FULL_LVL);
  assign push     = in_valid && in_ready;
  // Pop decision uses registered occupancy, so a fresh push is never popped on the same edge.
  assign pop      = (state_q == ACCUM) && (level != '0);

  assign pop_dat  = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_id   = pop_dat[7:0];
  assign pop_vote = pop_dat[8] && ({1'b0, pop_id} < NCLASS_W);

  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_votes = out_votes_q;
  assign err       = err_q;

  // Next-state pointers and running maximum for the current scan index
  always_comb begin
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    scan_hit   = (cnt_q[idx_q] > best_cnt_q);
    scan_cnt_d = scan_hit ? cnt_q[idx_q] : best_cnt_q;
    scan_id_d  = scan_hit ? 8'(idx_q) : best_id_q;
  end

  // FIFO data write; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_class;
  end

  // FIFO pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Collector FSM: tally votes, scan for the winner, hold it, then clear the tally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      for (int i = 0; i < NCLASS; i++) cnt_q[i] <= '0;
      rcv_q       <= '0;
      idx_q       <= '0;
      best_cnt_q  <= '0;
      best_id_q   <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_votes_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (pop) begin
            rcv_q <= rcv_q + 8'd1;
            if (pop_vote) begin
              if (cnt_q[pop_id[CW-1:0]] != 8'hFF)
                cnt_q[pop_id[CW-1:0]] <= cnt_q[pop_id[CW-1:0]] + 8'd1;
            end else begin
              err_q <= 1'b1;
            end
            if (rcv_q == LAST_RCV) begin
              state_q    <= SCAN;
              idx_q      <= '0;
              best_cnt_q <= '0;
              best_id_q  <= '0;
            end
          end
        end
        SCAN: begin
          best_cnt_q <= scan_cnt_d;
          best_id_q  <= scan_id_d;
          if (idx_q == LAST_IDX) begin
            state_q     <= EMIT;
            out_valid_q <= 1'b1;
            out_class_q <= scan_id_d;
            out_votes_q <= scan_cnt_d;
          end else begin
            idx_q <= idx_q + CW'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= CLEAR;
          end
        end
        CLEAR: begin
          for (int i = 0; i < NCLASS; i++) cnt_q[i] <= '0;
          rcv_q   <= '0;
          state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule
